// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite command master.
package axi_lite_master_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    AR     = 3'd3,
    WAIT_R = 3'd4,
    RSP    = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_master_wdog.sv
// Saturating transaction watchdog with a sticky flag; the whole module exists
// only when AXI_LITE_MASTER_TIMEOUT_EN is defined.
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
module axi_lite_master_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic count_en,
  input  logic timeout_clr,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          flag_r;
  logic          flag_s;
  logic          inc_s;
  logic          hit_s;

  // Next counter and flag; the flag sets on the edge the counter reaches the limit.
  always_comb begin
    cnt_s  = cnt_r;
    flag_s = flag_r;
    inc_s  = count_en && (cnt_r != LIMIT);
    hit_s  = inc_s && (cnt_r == LIMIT_M1);
    if (clear) begin
      cnt_s = {CW{1'b0}};
    end else if (inc_s) begin
      cnt_s = cnt_r + CW'(1);
    end else begin
      cnt_s = cnt_r;
    end
    if (hit_s) begin
      flag_s = 1'b1;
    end else if (timeout_clr) begin
      flag_s = 1'b0;
    end else begin
      flag_s = flag_r;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_r  <= {CW{1'b0}};
      flag_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      flag_r <= flag_s;
    end
  end

  assign timeout = flag_r;

endmodule
`endif

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
// Optional watchdog: define AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master_cmd
  import axi_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic                  timeout,
  input  logic                  timeout_clr,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_e                state_r, state_s;
  logic                  cmd_ready_r, cmd_ready_s;
  logic                  awvalid_r, awvalid_s;
  logic                  wvalid_r, wvalid_s;
  logic                  bready_r, bready_s;
  logic                  arvalid_r, arvalid_s;
  logic                  rready_r, rready_s;
  logic                  aw_done_r, aw_done_s;
  logic                  w_done_r, w_done_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic                  rsp_write_r, rsp_write_s;
  logic [31:0]           rsp_rdata_r, rsp_rdata_s;
  logic [1:0]            rsp_resp_r, rsp_resp_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [31:0]           wdata_r, wdata_s;
  logic [3:0]            wstrb_r, wstrb_s;
  logic                  busy_r;
  logic                  accept_s;

  // Next-state and next-output logic; every output is the registered copy of its _s value.
  always_comb begin
    state_s     = state_r;
    cmd_ready_s = 1'b0;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    bready_s    = bready_r;
    arvalid_s   = arvalid_r;
    rready_s    = rready_r;
    aw_done_s   = aw_done_r;
    w_done_s    = w_done_r;
    rsp_valid_s = rsp_valid_r;
    rsp_write_s = rsp_write_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_resp_s  = rsp_resp_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    wstrb_s     = wstrb_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s  = 1'b1;
          addr_s    = cmd_addr;
          wdata_s   = cmd_wdata;
          wstrb_s   = cmd_wstrb;
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
          if (cmd_write) begin
            state_s   = WR;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            state_s   = AR;
            arvalid_s = 1'b1;
          end
        end else begin
          cmd_ready_s = 1'b1;
        end
      end
      WR: begin
        // AW and W retire independently; leave only once both have handshaken.
        awvalid_s = awvalid_r & ~m_axi_awready;
        wvalid_s  = wvalid_r & ~m_axi_wready;
        aw_done_s = aw_done_r | (awvalid_r & m_axi_awready);
        w_done_s  = w_done_r | (wvalid_r & m_axi_wready);
        if (aw_done_s && w_done_s) begin
          state_s  = WAIT_B;
          bready_s = 1'b1;
        end else begin
          state_s = WR;
        end
      end
      WAIT_B: begin
        if (m_axi_bvalid) begin
          bready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_write_s = 1'b1;
          rsp_rdata_s = 32'h0000_0000;
          rsp_resp_s  = m_axi_bresp;
          state_s     = RSP;
        end else begin
          state_s = WAIT_B;
        end
      end
      AR: begin
        if (m_axi_arready) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = WAIT_R;
        end else begin
          state_s = AR;
        end
      end
      WAIT_R: begin
        if (m_axi_rvalid) begin
          rready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_write_s = 1'b0;
          rsp_rdata_s = m_axi_rdata;
          rsp_resp_s  = m_axi_rresp;
          state_s     = RSP;
        end else begin
          state_s = WAIT_R;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          cmd_ready_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = RSP;
        end
      end
      default: begin
        state_s     = IDLE;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_resp_r  <= OKAY;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'h0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= cmd_ready_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      bready_r    <= bready_s;
      arvalid_r   <= arvalid_s;
      rready_r    <= rready_s;
      aw_done_r   <= aw_done_s;
      w_done_r    <= w_done_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_write_r <= rsp_write_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_resp_r  <= rsp_resp_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      wstrb_r     <= wstrb_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_write     = rsp_write_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign busy          = busy_r;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  logic count_en_s;
  assign count_en_s = (state_r == WR) || (state_r == WAIT_B) ||
                      (state_r == AR) || (state_r == WAIT_R);

  axi_lite_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .aclk       (aclk),
    .areset     (areset),
    .clear      (accept_s),
    .count_en   (count_en_s),
    .timeout_clr(timeout_clr),
    .timeout    (timeout)
  );
`else
  logic wdog_unused_s;
  assign wdog_unused_s = timeout_clr & (TIMEOUT_CYCLES > 0) & accept_s;
  assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Scoreboard bench for axi_lite_master_cmd against a behavioural AXI4-Lite memory slave.
`timescale 1ns/1ps
module tb_axi_lite_master_cmd;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic        aclk = 1'b0, areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, timeout_clr = 1'b0;
  logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        cmd_ready, rsp_valid, rsp_write, busy, timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = 32'h0;

  // slave state and knobs
  logic        slv_clear = 1'b1, b_block = 1'b0;
  logic [1:0]  rresp_cfg = 2'b00;
  int          w_delay = 0, aw_wait = 0, w_wait = 0;
  logic        aw_have = 1'b0, w_have = 1'b0, ar_have = 1'b0, b_hs = 1'b0, r_hs = 1'b0;
  logic [31:0] aw_addr_q = 32'h0, ar_addr_q = 32'h0, w_data_q = 32'h0;
  logic [3:0]  w_strb_q = 4'h0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
  logic [31:0] mem [0:63];

  logic [31:0] model_mem [0:63];
  exp_t        sb_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;

  axi_lite_master_cmd #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .timeout(timeout), .timeout_clr(timeout_clr),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Slave acts at negedge: anything valid&&ready here handshakes at the next posedge.
  always @(negedge aclk) begin
    if (slv_clear) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
      aw_have = 1'b0; w_have = 1'b0; ar_have = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (b_hs) begin m_axi_bvalid = 1'b0; b_hs = 1'b0; end
      if (r_hs) begin m_axi_rvalid = 1'b0; r_hs = 1'b0; end
      if (!m_axi_bvalid && aw_have && w_have && !b_block) begin
        for (int i = 0; i < 4; i++)
          if (w_strb_q[i]) mem[aw_addr_q[7:2]][8*i +: 8] = w_data_q[8*i +: 8];
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; aw_have = 1'b0; w_have = 1'b0;
      end
      if (!m_axi_rvalid && ar_have) begin
        m_axi_rvalid = 1'b1; m_axi_rdata = mem[ar_addr_q[7:2]]; m_axi_rresp = rresp_cfg;
        ar_have = 1'b0;
      end
      m_axi_awready = 1'b0;
      if (m_axi_awvalid && !aw_have) m_axi_awready = 1'b1;
      if (m_axi_awready) begin aw_have = 1'b1; aw_addr_q = m_axi_awaddr; aw_hs_cnt++; end
      m_axi_wready = 1'b0;
      if (m_axi_wvalid && !w_have) begin
        if (w_wait >= w_delay) m_axi_wready = 1'b1;
        else w_wait++;
      end
      if (m_axi_wready) begin
        w_have = 1'b1; w_data_q = m_axi_wdata; w_strb_q = m_axi_wstrb; w_wait = 0; w_hs_cnt++;
      end
      m_axi_arready = m_axi_arvalid && !ar_have && !m_axi_rvalid;
      if (m_axi_arready) begin ar_have = 1'b1; ar_addr_q = m_axi_araddr; end
      b_hs = m_axi_bvalid && m_axi_bready;
      if (b_hs) b_hs_cnt++;
      r_hs = m_axi_rvalid && m_axi_rready;
    end
  end

  function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) model_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Returns at the sample point one cycle after the accepting edge (cycle 1).
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic ok, output int acc);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    ok = 1'b0; acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin tick(); ok = 1'b1; acc = cyc; break; end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok, output logic w, output logic [31:0] d,
                          output logic [1:0] r, output int rc);
    ok = 1'b0; w = 1'b0; d = 32'h0; r = 2'b00; rc = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        ok = 1'b1; w = rsp_write; d = rsp_rdata; r = rsp_resp; rc = cyc;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; slv_clear = 1'b1;
    repeat (3) tick();
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0) begin
      failures++; $display("FAIL reset_axi: got %b exp 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}); end
    checks++; if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp} !== 36'h0) begin
      failures++; $display("FAIL reset_rsp: got %h exp 0", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}); end
    checks++; if ({busy, timeout} !== 2'b00) begin failures++; $display("FAIL reset_busy_timeout: got %b exp 00", {busy, timeout}); end
    areset = 1'b0; slv_clear = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready: got %b exp 1", cmd_ready); end
    checks++; if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin failures++; $display("FAIL prot: got %b exp 0", {m_axi_awprot, m_axi_arprot}); end
  endtask

  task automatic test_write_read();
    logic ok, gw; logic [31:0] gd; logic [1:0] gr; int ac, rc; exp_t e;
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    sb_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b00});
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ok, ac);
    checks++; if ({ok, m_axi_awvalid, m_axi_wvalid, busy, cmd_ready} !== 5'b11110) begin
      failures++; $display("FAIL wr_cycle1: got %b exp 11110", {ok, m_axi_awvalid, m_axi_wvalid, busy, cmd_ready}); end
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp}) begin
      failures++; $display("FAIL wr_rsp: got ok=%b w=%b d=%h r=%0d exp w=%b d=%h r=%0d", ok, gw, gd, gr, e.wr, e.rdata, e.resp); end
    checks++; if (rc - ac + 1 !== 3) begin failures++; $display("FAIL wr_latency: got %0d exp 3", rc - ac + 1); end
    checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL wr_idle: got %b exp 10", {cmd_ready, busy}); end
    sb_q.push_back('{wr: 1'b0, rdata: model_mem[4], resp: 2'b00});
    issue(1'b0, 32'h10, 32'h0, 4'h0, ok, ac);
    checks++; if ({ok, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 4'b1100) begin
      failures++; $display("FAIL rd_cycle1: got %b exp 1100", {ok, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}); end
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp} || gd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_rsp: got ok=%b w=%b d=%h r=%0d exp w=%b d=%h r=%0d", ok, gw, gd, gr, e.wr, e.rdata, e.resp); end
    checks++; if (rc - ac + 1 !== 3) begin failures++; $display("FAIL rd_latency: got %0d exp 3", rc - ac + 1); end
  endtask

  task automatic test_skew();
    logic ok, gw, seen; logic [31:0] gd; logic [1:0] gr; int ac, rc, a0, w0, b0; exp_t e;
    w_delay = 3; a0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    model_write(32'h30, 32'h55AA55AA, 4'hF);
    sb_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b00});
    issue(1'b1, 32'h30, 32'h55AA55AA, 4'hF, ok, ac);
    tick();
    checks++; if ({ok, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 4'b1010) begin
      failures++; $display("FAIL skew_aw_drop: got %b exp 1010", {ok, m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp}) begin
      failures++; $display("FAIL skew_rsp: got ok=%b w=%b d=%h r=%0d", ok, gw, gd, gr); end
    seen = 1'b0;
    repeat (4) begin tick(); seen = seen | rsp_valid; end
    checks++; if ({aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0, 31'(seen)} !== {32'd1, 32'd1, 32'd1, 31'd0}) begin
      failures++; $display("FAIL skew_counts: got aw=%0d w=%0d b=%0d extra_rsp=%b exp 1 1 1 0", aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0, seen); end
    w_delay = 0;
  endtask

  task automatic test_partial_strobe();
    logic ok, gw; logic [31:0] gd; logic [1:0] gr; int ac, rc; exp_t e;
    model_write(32'h20, 32'hAAAAAAAA, 4'hF);
    model_write(32'h20, 32'h11223344, 4'b0011);
    issue(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, ok, ac);
    wait_rsp(ok, gw, gd, gr, rc);
    issue(1'b1, 32'h20, 32'h11223344, 4'b0011, ok, ac);
    wait_rsp(ok, gw, gd, gr, rc);
    sb_q.push_back('{wr: 1'b0, rdata: model_mem[8], resp: 2'b00});
    issue(1'b0, 32'h20, 32'h0, 4'h0, ok, ac);
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp} || gd !== 32'hAAAA3344) begin
      failures++; $display("FAIL strobe_rsp: got ok=%b w=%b d=%h r=%0d exp d=%h", ok, gw, gd, gr, e.rdata); end
  endtask

  task automatic test_error_backpressure();
    logic ok, gw; logic [31:0] gd; logic [1:0] gr; int ac, rc; exp_t e;
    rresp_cfg = 2'b10;
    sb_q.push_back('{wr: 1'b0, rdata: model_mem[4], resp: 2'b10});
    issue(1'b0, 32'h10, 32'h0, 4'h0, ok, ac);
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp}) begin
      failures++; $display("FAIL slverr_rsp: got ok=%b w=%b d=%h r=%0d exp r=%0d", ok, gw, gd, gr, e.resp); end
    rresp_cfg = 2'b00;
    sb_q.push_back('{wr: 1'b0, rdata: model_mem[8], resp: 2'b00});
    issue(1'b0, 32'h20, 32'h0, 4'h0, ok, ac);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    gw = rsp_write; gd = rsp_rdata; gr = rsp_resp;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({ok, rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp} !== {3'b110, gw, gd, gr}) begin
        failures++; $display("FAIL bp_hold[%0d]: got ok=%b v=%b crdy=%b w=%b d=%h r=%0d", i, ok, rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp); end
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    e = sb_q.pop_front();
    checks++; if ({gw, gd, gr} !== {e.wr, e.rdata, e.resp} || {rsp_valid, cmd_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_rsp: got w=%b d=%h r=%0d v=%b crdy=%b exp d=%h", gw, gd, gr, rsp_valid, cmd_ready, e.rdata); end
  endtask

  task automatic test_reset_mid();
    logic ok, gw; logic [31:0] gd; logic [1:0] gr; int ac, rc; exp_t e;
    b_block = 1'b1;
    issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF, ok, ac);
    for (int i = 0; i < 20; i++) begin
      if (m_axi_bready) break;
      tick();
    end
    checks++; if ({ok, m_axi_bready} !== 2'b11) begin failures++; $display("FAIL mid_reach_waitb: got %b exp 11", {ok, m_axi_bready}); end
    areset = 1'b1; slv_clear = 1'b1;
    tick();
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, busy} !== 7'b0) begin
      failures++; $display("FAIL mid_reset: got %b exp 0000000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid, busy}); end
    areset = 1'b0; slv_clear = 1'b0; b_block = 1'b0;
    tick();
    sb_q.push_back('{wr: 1'b0, rdata: model_mem[8], resp: 2'b00});
    issue(1'b0, 32'h20, 32'h0, 4'h0, ok, ac);
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp}) begin
      failures++; $display("FAIL mid_read_after: got ok=%b w=%b d=%h r=%0d exp d=%h", ok, gw, gd, gr, e.rdata); end
  endtask

  task automatic test_timeout();
    logic ok, gw; logic [31:0] gd; logic [1:0] gr; int ac, rc; exp_t e;
    b_block = 1'b1;
    model_write(32'h08, 32'h12345678, 4'hF);
    sb_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b00});
    issue(1'b1, 32'h08, 32'h12345678, 4'hF, ok, ac);
    repeat (7) tick();
    checks++; if ({ok, timeout} !== 2'b10) begin failures++; $display("FAIL to_cycle8: got %b exp 10", {ok, timeout}); end
    tick();
    checks++; if (timeout !== TO_EN) begin failures++; $display("FAIL to_cycle9: got %b exp %b", timeout, TO_EN); end
    checks++; if (m_axi_bready !== 1'b1) begin failures++; $display("FAIL to_no_abort: bready got %b exp 1", m_axi_bready); end
    timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clear: got %b exp 0", timeout); end
    b_block = 1'b0;
    wait_rsp(ok, gw, gd, gr, rc);
    e = sb_q.pop_front();
    checks++; if (ok !== 1'b1 || {gw, gd, gr} !== {e.wr, e.rdata, e.resp} || timeout !== 1'b0) begin
      failures++; $display("FAIL to_late_rsp: got ok=%b w=%b d=%h r=%0d to=%b", ok, gw, gd, gr, timeout); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish exp finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_write_read();
    test_skew();
    test_partial_strobe();
    test_error_backpressure();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
- Single-outstanding AXI4-Lite initiator (manager).
- Converts a simple valid/ready command port into one AXI4-Lite read or write, then returns the response on a valid/ready response port.
- Drives memory-mapped AXI4-Lite slaves in benches and in the SoC.
- Complements the memory-style AXI4-Lite slaves already in the platform.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, m_axi_awaddr and m_axi_araddr.
- TIMEOUT_CYCLES, 1024, watchdog limit in aclk cycles; used only with the optional feature.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address, passed unaltered.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP copy.
- busy  out  1  high in any state other than IDLE.
- timeout  out  1  sticky watchdog flag.
- timeout_clr  in  1  clears timeout.
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite manager directions, 32-bit data, 4-bit strobe, 3-bit prot.

Behaviour:
- Reset values (areset=1 at an edge): all AXI valid/ready outputs 0, cmd_ready 0, rsp_valid 0, rsp_* 0, busy 0, timeout 0, state IDLE.
- Reset mid-transaction aborts immediately: next edge is IDLE with all valids low.
- awprot and arprot are constant 3'b000.
- State IDLE:
  - cmd_ready=1 (registered, asserted the cycle after reset deasserts).
  - On accept, latch cmd_*. Next state is WR if cmd_write, else AR.
- State WR:
  - awvalid=1 and wvalid=1 asserted in the same cycle.
  - Each drops on its own handshake and never drops before it.
  - When both handshakes have completed (same or different cycles), go to WAIT_B with bready=1.
- State WAIT_B:
  - On bvalid: capture bresp, rsp_write=1, rsp_rdata=0. Drop bready and go to RSP.
- State AR:
  - arvalid=1 until arready. Then rready=1 and go to WAIT_R.
- State WAIT_R:
  - On rvalid: capture rdata and rresp, rsp_write=0. Drop rready and go to RSP.
- State RSP:
  - rsp_valid=1 and rsp_* held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - cmd_ready stays 0 until IDLE is entered, so there is a 1-cycle gap between back-to-back commands.
- Minimum latency with a zero-wait slave: accept at cycle 0, valid at cycle 1, bready/rready at cycle 2, rsp_valid at cycle 3.
- SLVERR/DECERR responses are passed through unchanged; no retry.
- Only one transaction is ever outstanding; AW/W and AR are never active together.
- A stray bvalid/rvalid while not waiting is ignored (ready is low).

Optional Feature:
- Macro AXI_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on command accept and increments in WR, WAIT_B, AR and WAIT_R.
  - On reaching TIMEOUT_CYCLES it sets timeout=1 (sticky) and saturates.
  - The transaction is not aborted; AXI valids stay asserted per protocol.
  - timeout_clr=1 clears the flag on the next edge. If set and clear occur in the same cycle, set wins.
- Undefined: timeout is tied to 0, timeout_clr is ignored, and no counter logic exists.

Decomposition:
- Package axi_lite_master_pkg holds:
  - response codes: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11;
  - state encoding: IDLE, WR, WAIT_B, AR, WAIT_R, RSP;
  - the PROT default of 3'b000.
- Sub-module axi_lite_master_wdog contains the saturating watchdog counter and sticky flag, instantiated only under the macro.

Test Plan:
- Write then read, zero-wait behavioural AXI4-Lite memory slave:
  - write 0x10 with 0xDEADBEEF, wstrb 4'hF -> rsp_resp 0, rsp_write 1, rsp_valid at cycle 3;
  - read 0x10 -> rsp_rdata 0xDEADBEEF, rsp_resp 0.
- Skewed handshakes: slave asserts awready 3 cycles before wready -> awvalid drops after its handshake, wvalid holds, exactly one B accepted, exactly one rsp.
- Partial strobe: write 0x11223344 to 0x20 with wstrb 4'b0011 over preset 0xAAAAAAAA -> read returns 0xAAAA3344.
- Error and backpressure:
  - slave returns rresp 2'b10 -> rsp_resp 2'b10;
  - rsp_ready held low 5 cycles -> rsp_* stable and cmd_ready 0 throughout.
- Reset mid-transaction: areset pulsed in WAIT_B -> next cycle all valids 0, busy 0. A following read completes correctly.
- Macro on, TIMEOUT_CYCLES=8, slave never asserts bvalid -> timeout=1 at cycle 9 after accept. timeout_clr clears it. Late bvalid still yields rsp.
